pipe_exec_unit: RTL
===================

Name: pipe_exec_unit

Overview:
- Parametrised, handshaked successor of the single-cycle execute ALU.
- Registers every result behind a valid/ready output stage.
- Adds an iterative multiplier (ALU_MULQ low half, ALU_UMULH high half) taking MULT_STAGES cycles.
- Supports squash of in-flight work on branch recovery; sits between issue/decode and writeback in the EX stage.

Parameters:
- XLEN, 64, datapath width; multiple of 32, at least 32.
- MULT_STAGES, 4, multiply iterations; power of 2 dividing XLEN; XLEN/MULT_STAGES opb bits consumed per cycle.
- TAG_W, 5, width of the destination tag carried alongside each op.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous active-high reset
- squash  in  1  kill in-flight multiply and any pending output
- in_valid  in  1  operation offered
- in_ready  out  1  unit accepts operation this cycle
- in_opa  in  XLEN  operand A
- in_opb  in  XLEN  operand B
- in_func  in  5  ALU function; shared ALU func encoding plus ALU_MULQ, ALU_UMULH
- in_tag  in  TAG_W  destination tag
- out_valid  out  1  result available
- out_ready  in  1  consumer takes result
- out_result  out  XLEN  result
- out_tag  out  TAG_W  tag of result

Behaviour:
- Interface: one clock; reset is synchronous and active-high; ports named clock and reset.
- Reset values: out_valid=0, out_result=0, out_tag=0, FSM=IDLE, iteration counter=0, accumulator=0.
- in_ready is combinational: (state==IDLE) && (!out_valid || out_ready) && !squash.
- Accept means in_valid && in_ready on a rising clock edge.
- FSM states: IDLE, MULT.
- IDLE, non-multiply op accepted:
  - Next cycle: out_result = ALU(opa, opb), out_tag = in_tag, out_valid = 1.
  - Latency 1; throughput 1 per cycle while out_ready=1.
- IDLE, ALU_MULQ/ALU_UMULH accepted:
  - Latch opa, opb, func, tag; go to MULT; counter=0; accumulator (2*XLEN bits) = 0.
- MULT, each cycle:
  - accumulator += (opa * opb chunk[counter]) << (counter*XLEN/MULT_STAGES), unsigned; counter++.
  - When counter reaches MULT_STAGES-1, that cycle's update completes the product.
  - Next edge: out_result = low XLEN bits (MULQ) or high XLEN bits (UMULH); out_valid=1; state=IDLE.
  - Accept to out_valid = MULT_STAGES+1 edges.
  - in_ready=0 throughout MULT. Because in_ready in IDLE requires the output slot free, MULT never completes into an occupied slot.
- Output hold: while out_valid && !out_ready, out_result/out_tag stable and no new op accepted. out_valid falls the edge after out_ready if nothing new is accepted.
- Pass-through: out_valid && out_ready with a new non-multiply op accepted in the same cycle replaces the output register, and out_valid stays 1.
- ALU ops:
  - ADDQ/SUBQ wrap modulo 2^XLEN.
  - AND, BIC, BIS, ORNOT, XOR, EQV as bitwise.
  - Shift amount is opb[log2(XLEN)-1:0]. SRL logical; SLL; SRA sign-fills, and a shift of 0 returns opa unchanged.
  - CMPULT/CMPEQ/CMPULE unsigned; CMPLT/CMPLE signed. Result is zero-extended 0/1.
  - Undefined func: result is 32'hdeadbeef replicated XLEN/32 times; still completes with out_valid=1.
- Squash:
  - Next edge: out_valid=0, state=IDLE, counter=0.
  - No op is accepted in the squash cycle (in_ready=0).
  - squash has priority over completion, acceptance and out_ready.
- Reset mid-multiply: returns to reset values; the partial product is discarded.

Test Plan:
- Reset held 2 cycles, then released -> out_valid=0, out_result=0, in_ready=1. XLEN=64, MULT_STAGES=4 for all cases below.
- Back-to-back ADDQ 0xFFFFFFFFFFFFFFFF+1 (tag 3), then SRA 0x8000000000000000 by 4 (tag 4), out_ready=1 -> cycle 1: result 0, tag 3; cycle 2: result 0xF800000000000000, tag 4; out_valid continuous.
- MULQ and UMULH 0xFFFFFFFFFFFFFFFF*0xFFFFFFFFFFFFFFFF -> in_ready low 4 cycles; out_valid on 5th edge after accept; MULQ result 0x0000000000000001, UMULH result 0xFFFFFFFFFFFFFFFE.
- out_ready=0 for 3 cycles with CMPLT(-1, 1) pending -> result 1 held stable, in_ready=0, the next ADDQ is not accepted until out_ready=1.
- squash asserted on 2nd MULT cycle with in_valid=1 -> next edge: out_valid=0, state IDLE; no accept during squash; a subsequent ADDQ 2+3 returns 5 one cycle after accept.
- Undefined func 5'h1F -> out_result 0xdeadbeefdeadbeef, out_valid=1.

Source files
------------

// File: rtl/pipe_exec_unit.sv
// Pipelined EX-stage unit: single-cycle ALU ops and an iterative unsigned multiplier
// behind one valid/ready output register, with squash for branch recovery.
module pipe_exec_unit #(
   parameter int XLEN        = 64,
   parameter int MULT_STAGES = 4,
   parameter int TAG_W       = 5
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             squash,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [XLEN-1:0]  in_opa,
   input  logic [XLEN-1:0]  in_opb,
   input  logic [4:0]       in_func,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  out_result,
   output logic [TAG_W-1:0] out_tag
);

   localparam logic [4:0] ALU_ADDQ   = 5'h00;
   localparam logic [4:0] ALU_SUBQ   = 5'h01;
   localparam logic [4:0] ALU_CMPEQ  = 5'h02;
   localparam logic [4:0] ALU_CMPLT  = 5'h03;
   localparam logic [4:0] ALU_CMPLE  = 5'h04;
   localparam logic [4:0] ALU_CMPULT = 5'h05;
   localparam logic [4:0] ALU_CMPULE = 5'h06;
   localparam logic [4:0] ALU_AND    = 5'h07;
   localparam logic [4:0] ALU_BIC    = 5'h08;
   localparam logic [4:0] ALU_BIS    = 5'h09;
   localparam logic [4:0] ALU_ORNOT  = 5'h0A;
   localparam logic [4:0] ALU_XOR    = 5'h0B;
   localparam logic [4:0] ALU_EQV    = 5'h0C;
   localparam logic [4:0] ALU_SLL    = 5'h0D;
   localparam logic [4:0] ALU_SRL    = 5'h0E;
   localparam logic [4:0] ALU_SRA    = 5'h0F;
   localparam logic [4:0] ALU_MULQ   = 5'h10;
   localparam logic [4:0] ALU_UMULH  = 5'h11;

   localparam int CHUNK_W = XLEN / MULT_STAGES;
   localparam int CNT_W   = (MULT_STAGES > 1) ? $clog2(MULT_STAGES) : 1;
   localparam int SH_W    = $clog2(XLEN);
   localparam int PROD_W  = XLEN + CHUNK_W;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MULT_STAGES - 1);

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] MULT = 1'b1;

   logic [0:0]       state_q,  state_d;
   logic [CNT_W-1:0] cnt_q,    cnt_d;
   logic [2*XLEN-1:0] acc_q,   acc_d;
   logic [XLEN-1:0]  opa_q,    opa_d;
   logic [XLEN-1:0]  opb_q,    opb_d;
   logic             high_q,   high_d;
   logic [TAG_W-1:0] mulTag_q, mulTag_d;
   logic             valid_q,  valid_d;
   logic [XLEN-1:0]  result_q, result_d;
   logic [TAG_W-1:0] tag_q,    tag_d;

   logic              accept;
   logic              isMul;
   logic              mulDone;
   logic [SH_W-1:0]   shamt;
   logic [XLEN-1:0]   aluResult;
   logic [CHUNK_W-1:0] chunk;
   logic [PROD_W-1:0] prod;
   logic [2*XLEN-1:0] partial;
   logic [2*XLEN-1:0] accSum;

   assign isMul    = (in_func == ALU_MULQ) || (in_func == ALU_UMULH);
   assign in_ready = (state_q == IDLE) && (!valid_q || out_ready) && !squash;
   assign accept   = in_valid && in_ready;
   assign mulDone  = (state_q == MULT) && (cnt_q == LAST_CNT);

   assign out_valid  = valid_q;
   assign out_result = result_q;
   assign out_tag    = tag_q;

   // One slice of opb per cycle, weighted by its position in the full product.
   assign chunk   = opb_q[cnt_q*CHUNK_W +: CHUNK_W];
   assign prod    = PROD_W'(opa_q) * PROD_W'(chunk);
   assign partial = (2*XLEN)'(prod) << (cnt_q * CHUNK_W);
   assign accSum  = acc_q + partial;

   assign shamt = in_opb[SH_W-1:0];

   always_comb begin
      aluResult = {(XLEN/32){32'hdeadbeef}};
      case (in_func)
         ALU_ADDQ:   aluResult = in_opa + in_opb;
         ALU_SUBQ:   aluResult = in_opa - in_opb;
         ALU_CMPEQ:  aluResult = {{(XLEN-1){1'b0}}, (in_opa == in_opb)};
         ALU_CMPLT:  aluResult = {{(XLEN-1){1'b0}}, ($signed(in_opa) < $signed(in_opb))};
         ALU_CMPLE:  aluResult = {{(XLEN-1){1'b0}}, ($signed(in_opa) <= $signed(in_opb))};
         ALU_CMPULT: aluResult = {{(XLEN-1){1'b0}}, (in_opa < in_opb)};
         ALU_CMPULE: aluResult = {{(XLEN-1){1'b0}}, (in_opa <= in_opb)};
         ALU_AND:    aluResult = in_opa & in_opb;
         ALU_BIC:    aluResult = in_opa & ~in_opb;
         ALU_BIS:    aluResult = in_opa | in_opb;
         ALU_ORNOT:  aluResult = in_opa | ~in_opb;
         ALU_XOR:    aluResult = in_opa ^ in_opb;
         ALU_EQV:    aluResult = ~(in_opa ^ in_opb);
         ALU_SLL:    aluResult = in_opa << shamt;
         ALU_SRL:    aluResult = in_opa >> shamt;
         ALU_SRA:    aluResult = $signed(in_opa) >>> shamt;
         default:    aluResult = {(XLEN/32){32'hdeadbeef}};
      endcase
   end

   // Squash overrides everything; otherwise a new ALU op wins the output slot,
   // then a finishing multiply, then a plain drain when the consumer takes the result.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      opa_d    = opa_q;
      opb_d    = opb_q;
      high_d   = high_q;
      mulTag_d = mulTag_q;
      valid_d  = valid_q;
      result_d = result_q;
      tag_d    = tag_q;

      if (squash) begin
         valid_d = 1'b0;
         state_d = IDLE;
         cnt_d   = '0;
      end else begin
         if (state_q == IDLE) begin
            if (accept && isMul) begin
               state_d  = MULT;
               cnt_d    = '0;
               acc_d    = '0;
               opa_d    = in_opa;
               opb_d    = in_opb;
               high_d   = (in_func == ALU_UMULH);
               mulTag_d = in_tag;
            end
         end else begin
            acc_d = accSum;
            cnt_d = cnt_q + 1'b1;
            if (mulDone) begin
               state_d = IDLE;
               cnt_d   = '0;
            end
         end

         if (accept && !isMul) begin
            valid_d  = 1'b1;
            result_d = aluResult;
            tag_d    = in_tag;
         end else if (mulDone) begin
            valid_d  = 1'b1;
            result_d = high_q ? accSum[2*XLEN-1:XLEN] : accSum[XLEN-1:0];
            tag_d    = mulTag_q;
         end else if (out_ready) begin
            valid_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         acc_q    <= '0;
         opa_q    <= '0;
         opb_q    <= '0;
         high_q   <= 1'b0;
         mulTag_q <= '0;
         valid_q  <= 1'b0;
         result_q <= '0;
         tag_q    <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         opa_q    <= opa_d;
         opb_q    <= opb_d;
         high_q   <= high_d;
         mulTag_q <= mulTag_d;
         valid_q  <= valid_d;
         result_q <= result_d;
         tag_q    <= tag_d;
      end
   end

endmodule
